// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Stalls the core during misses and moves whole lines to/from main memory.
module dcache_ctrl #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int LINES  = 16,
  parameter int WORDS  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_read,
  input  logic                    cpu_write,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_ready,
  output logic                    cpu_stall,
  output logic                    hit,
  output logic                    dirty,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [WORDS*DATA_W-1:0] mem_wdata,
  input  logic [WORDS*DATA_W-1:0] mem_rdata,
  input  logic                    mem_ready
);
  localparam int BYTE_W  = $clog2(DATA_W / 8);
  localparam int OFF_W   = $clog2(WORDS);
  localparam int IDX_W   = $clog2(LINES);
  localparam int TAG_W   = ADDR_W - IDX_W - OFF_W - BYTE_W;
  localparam int LINE_W  = WORDS * DATA_W;
  localparam int LBASE_W = $clog2(LINE_W);

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_WRITEBACK, S_ALLOCATE} state_t;

  state_t                  state_q, state_d;
  logic                    op_wr_q;
  logic [ADDR_W-1:BYTE_W]  addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [DATA_W-1:0]       cpu_rdata_q, cpu_rdata_d;
  logic                    cpu_ready_q, cpu_ready_d;
  logic                    hit_q, hit_d, dirty_q, dirty_d;
  logic                    mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]       mem_wdata_q, mem_wdata_d;

  logic [LINES-1:0]        valid_q, dirty_line_q;
  logic [TAG_W-1:0]        tag_q  [LINES];
  logic [LINE_W-1:0]       data_q [LINES];

  logic                    accept, wr_hit, wb_done, fill;
  logic [IDX_W-1:0]        idx;
  logic [TAG_W-1:0]        req_tag;
  logic [OFF_W-1:0]        woff;
  logic [LBASE_W-1:0]      wbase;
  logic                    lk_hit, lk_dirty;
  logic [ADDR_W-1:0]       refill_addr, victim_addr;
  logic                    unused_byte_bits;

  assign unused_byte_bits = ^cpu_addr[BYTE_W-1:0];

  assign idx         = addr_q[BYTE_W+OFF_W +: IDX_W];
  assign req_tag     = addr_q[ADDR_W-1 -: TAG_W];
  assign woff        = addr_q[BYTE_W +: OFF_W];
  assign wbase       = LBASE_W'(woff) << $clog2(DATA_W);
  assign lk_hit      = valid_q[idx] && (tag_q[idx] == req_tag);
  assign lk_dirty    = valid_q[idx] && dirty_line_q[idx];
  assign refill_addr = {req_tag, idx, {(OFF_W+BYTE_W){1'b0}}};
  assign victim_addr = {tag_q[idx], idx, {(OFF_W+BYTE_W){1'b0}}};

  always_comb begin
    state_d     = state_q;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    hit_d       = hit_q;
    dirty_d     = dirty_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    accept      = 1'b0;
    wr_hit      = 1'b0;
    wb_done     = 1'b0;
    fill        = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The request is still held during the ready cycle; do not take it twice.
        if ((cpu_read || cpu_write) && !cpu_ready_q) begin
          accept  = 1'b1;
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        hit_d   = lk_hit;
        dirty_d = lk_dirty;
        if (lk_hit) begin
          cpu_ready_d = 1'b1;
          state_d     = S_IDLE;
          if (op_wr_q) wr_hit = 1'b1;
          else         cpu_rdata_d = data_q[idx][wbase +: DATA_W];
        end else if (lk_dirty) begin
          state_d     = S_WRITEBACK;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = victim_addr;
          mem_wdata_d = data_q[idx];
        end else begin
          state_d    = S_ALLOCATE;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = refill_addr;
        end
      end
      S_WRITEBACK: begin
        // mem_req stays high so the refill follows without an idle cycle.
        if (mem_ready) begin
          wb_done    = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = refill_addr;
          state_d    = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        if (mem_ready) begin
          fill      = 1'b1;
          mem_req_d = 1'b0;
          state_d   = S_COMPARE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cpu_ready_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      hit_q        <= 1'b0;
      dirty_q      <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      valid_q      <= '0;
      dirty_line_q <= '0;
      op_wr_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q     <= state_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      hit_q       <= hit_d;
      dirty_q     <= dirty_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (accept) begin
        op_wr_q <= cpu_write;
        addr_q  <= cpu_addr[ADDR_W-1:BYTE_W];
        wdata_q <= cpu_wdata;
      end
      if (wr_hit)  dirty_line_q[idx] <= 1'b1;
      if (wb_done) dirty_line_q[idx] <= 1'b0;
      if (fill) begin
        valid_q[idx]      <= 1'b1;
        dirty_line_q[idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_hit) data_q[idx][wbase +: DATA_W] <= wdata_q;
    if (fill) begin
      data_q[idx] <= mem_rdata;
      tag_q[idx]  <= req_tag;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign cpu_stall = (state_q != S_IDLE) || ((cpu_read || cpu_write) && !cpu_ready_q);
  assign hit       = hit_q;
  assign dirty     = dirty_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: flat reference memory for CPU data, queued expected
// memory transactions checked by a latency-programmable memory responder.
module tb_dcache_ctrl;
  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_read, cpu_write;
  logic [63:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic         cpu_ready, cpu_stall, hit, dirty;
  logic         mem_req, mem_we, mem_ready;
  logic [63:0]  mem_addr;
  logic [255:0] mem_wdata, mem_rdata;

  dcache_ctrl #(.ADDR_W(64), .DATA_W(64), .LINES(16), .WORDS(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_stall(cpu_stall),
    .hit(hit), .dirty(dirty),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat  = 2;

  typedef struct { bit is_read; logic [63:0] rdata; } cpu_exp_t;
  typedef struct { bit we; logic [63:0] addr; logic [255:0] wdata; } mem_exp_t;
  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];

  logic [63:0] ref_mem [logic [63:0]];
  logic [63:0] bmem    [logic [63:0]];

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] init_word(input logic [63:0] a);
    return 64'hC0DE_0000_0000_0000 | a;
  endfunction

  function automatic logic [63:0] ref_rd(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [63:0] bmem_rd(input logic [63:0] a);
    return bmem.exists(a) ? bmem[a] : init_word(a);
  endfunction

  task automatic push_mem(input bit we, input logic [63:0] addr);
    mem_exp_t m;
    m.we = we; m.addr = addr; m.wdata = '0;
    if (we) for (int i = 0; i < 4; i++) m.wdata[i*64 +: 64] = ref_rd(addr + 64'(i*8));
    mem_q.push_back(m);
  endtask

  // Memory responder: mem_ready after mem_lat cycles of mem_req, checks hold stability.
  initial begin
    int wait_cnt = 0;
    logic         t_we;
    logic [63:0]  t_addr;
    logic [255:0] t_wdata;
    mem_exp_t     m;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (reset || !mem_req) wait_cnt = 0;
      else begin
        if (wait_cnt == 0) begin
          t_we = mem_we; t_addr = mem_addr; t_wdata = mem_wdata;
        end else begin
          check_eq("mem_addr_hold", mem_addr, t_addr);
          check_eq("mem_we_hold", mem_we, t_we);
          check_eq("mem_wdata_hold", mem_wdata, t_wdata);
          check_eq("stall_in_xfer", cpu_stall, 1'b1);
          check_eq("ready_in_xfer", cpu_ready, 1'b0);
        end
        if (wait_cnt == mem_lat) begin
          mem_ready = 1'b1;
          wait_cnt  = 0;
          if (mem_q.size() == 0) check_eq("mem_unexpected_xfer", mem_addr, '1);
          else begin
            m = mem_q.pop_front();
            check_eq("mem_we", t_we, m.we);
            check_eq("mem_addr", t_addr, m.addr);
            if (m.we) check_eq("mem_wdata", t_wdata, m.wdata);
          end
          for (int i = 0; i < 4; i++) begin
            if (t_we) bmem[t_addr + 64'(i*8)] = t_wdata[i*64 +: 64];
            else      mem_rdata[i*64 +: 64] = bmem_rd(t_addr + 64'(i*8));
          end
        end else wait_cnt++;
      end
    end
  end

  task automatic cpu_access(input bit rd, input bit wr, input logic [63:0] addr, input logic [63:0] wd,
                            input int lat_exp, input bit miss_exp, input bit miss_dirty_exp,
                            input bit dirty_exp);
    cpu_exp_t e;
    int  cycles = 0;
    bit  got = 0, saw_req = 0;
    logic h0 = 1'b0, d0 = 1'b0;
    e.is_read = rd && !wr;
    e.rdata   = e.is_read ? ref_rd(addr) : '0;
    cpu_q.push_back(e);
    if (wr) ref_mem[addr] = wd;
    cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_wdata = wd;
    while (!got && cycles < 200) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (mem_req && !saw_req) begin saw_req = 1; h0 = hit; d0 = dirty; end
      if (cpu_ready) got = 1;
    end
    cpu_read = 1'b0; cpu_write = 1'b0;
    e = cpu_q.pop_front();
    if (!got) begin
      check_eq("cpu_ready_timeout", 1'b0, 1'b1);
      return;
    end
    if (e.is_read) check_eq("cpu_rdata", cpu_rdata, e.rdata);
    check_eq("latency", cycles, lat_exp);
    check_eq("hit_final", hit, 1'b1);
    check_eq("dirty_final", dirty, dirty_exp);
    check_eq("mem_req_seen", saw_req, miss_exp);
    if (miss_exp) begin
      check_eq("hit_on_miss", h0, 1'b0);
      check_eq("dirty_on_miss", d0, miss_dirty_exp);
    end
    @(posedge clk);
    @(negedge clk);
    check_eq("ready_single_pulse", cpu_ready, 1'b0);
    check_eq("stall_after_done", cpu_stall, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit saw_wb = 0;
    reset = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cpu_ready", cpu_ready, 1'b0);
    check_eq("rst_cpu_rdata", cpu_rdata, '0);
    check_eq("rst_hit", hit, 1'b0);
    check_eq("rst_dirty", dirty, 1'b0);
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_mem_we", mem_we, 1'b0);
    check_eq("rst_mem_addr", mem_addr, '0);
    check_eq("rst_mem_wdata", mem_wdata, '0);
    check_eq("rst_stall", cpu_stall, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Cold miss, refill, then hits in the same line.
    mem_lat = 2;
    push_mem(1'b0, 64'h100);
    cpu_access(1, 0, 64'h100, '0, 6, 1, 0, 0);
    cpu_access(1, 0, 64'h108, '0, 2, 0, 0, 0);
    cpu_access(0, 1, 64'h110, 64'hDEADBEEF, 2, 0, 0, 0);
    cpu_access(1, 0, 64'h110, '0, 2, 0, 0, 1);

    // Conflict on index 8 with a dirty victim: write-back then refill.
    mem_lat = 1;
    push_mem(1'b1, 64'h100);
    push_mem(1'b0, 64'h2100);
    cpu_access(1, 0, 64'h2100, '0, 7, 1, 1, 0);

    // Read and write both high behaves as a write.
    cpu_access(1, 1, 64'h2108, 64'h1234_5678_9ABC_DEF0, 2, 0, 0, 0);
    cpu_access(1, 0, 64'h2108, '0, 2, 0, 0, 1);

    // Reset in the middle of a write-back abandons it.
    cpu_access(0, 1, 64'h2118, 64'h5555_AAAA_0000_FFFF, 2, 0, 0, 1);
    mem_lat = 20;
    cpu_read = 1'b1; cpu_addr = 64'h100;
    for (int i = 0; i < 10 && !saw_wb; i++) begin
      @(negedge clk);
      if (mem_req && mem_we) saw_wb = 1;
    end
    check_eq("wb_started", saw_wb, 1'b1);
    reset = 1'b1; cpu_read = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_mem_req", mem_req, 1'b0);
    check_eq("rst_mid_cpu_ready", cpu_ready, 1'b0);
    check_eq("rst_mid_hit", hit, 1'b0);
    check_eq("rst_mid_dirty", dirty, 1'b0);
    reset = 1'b0;
    ref_mem.delete();
    foreach (bmem[a]) ref_mem[a] = bmem[a];
    @(negedge clk);
    mem_lat = 2;
    push_mem(1'b0, 64'h100);
    cpu_access(1, 0, 64'h100, '0, 6, 1, 0, 0);
    cpu_access(1, 0, 64'h110, '0, 2, 0, 0, 0);

    // Long memory latency; holds checked in the responder.
    mem_lat = 5;
    push_mem(1'b0, 64'h300);
    cpu_access(1, 0, 64'h300, '0, 9, 1, 0, 0);
    cpu_access(0, 1, 64'h308, 64'hFEED_F00D_0BAD_CAFE, 2, 0, 0, 0);
    mem_lat = 0;
    push_mem(1'b1, 64'h300);
    push_mem(1'b0, 64'h100);
    cpu_access(1, 0, 64'h100, '0, 5, 1, 1, 0);
    push_mem(1'b0, 64'h40);
    cpu_access(1, 0, 64'h58, '0, 4, 1, 0, 0);
    mem_lat = 3;
    push_mem(1'b0, 64'h300);
    cpu_access(1, 0, 64'h308, '0, 7, 1, 0, 0);

    check_eq("mem_queue_drained", mem_q.size(), 0);
    check_eq("cpu_queue_drained", cpu_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
